regfile8x16: RTL and testbench

REGFILE8X16 -- requirements
Module: regfile8x16

---
 rtl/regfile8x16.sv | 83 ++++++++
 tb/tb_regfile8x16.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile8x16.sv
// 8-entry register file with one-hot write select, two combinational read ports
// with write-through bypass, a sticky invalid-select flag and a saturating write counter.
module regfile8x16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [7:0]       wsel_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [2:0]       raddr_a_i,
    input  logic [2:0]       raddr_b_i,
    output logic [WIDTH-1:0] rdata_a_o,
    output logic [WIDTH-1:0] rdata_b_o,
    input  logic             err_clr_i,
    output logic             sel_err_o,
    output logic [7:0]       wr_count_o
);

    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] regs_d [8];
    logic             sel_err_q, sel_err_d;
    logic [7:0]       wr_count_q, wr_count_d;

    logic sel_onehot;
    logic wr_valid;
    logic wr_invalid;
    logic bypass_a;
    logic bypass_b;

    // A power of two has exactly one bit set: x != 0 and x & (x-1) == 0.
    always_comb begin
        sel_onehot = (wsel_i != 8'h00) && ((wsel_i & (wsel_i - 8'd1)) == 8'h00);
        wr_valid   = we_i && sel_onehot;
        wr_invalid = we_i && !sel_onehot;
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = (wr_valid && wsel_i[i]) ? wdata_i : regs_q[i];
        end
        // Set wins over clear when both happen at the same edge.
        sel_err_d = sel_err_q;
        if (err_clr_i) begin
            sel_err_d = 1'b0;
        end
        if (wr_invalid) begin
            sel_err_d = 1'b1;
        end
        wr_count_d = wr_count_q;
        if (wr_valid && (wr_count_q != 8'hFF)) begin
            wr_count_d = wr_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            sel_err_q  <= 1'b0;
            wr_count_q <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            sel_err_q  <= sel_err_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Bypass is suppressed during reset so the read ports show the cleared state.
    always_comb begin
        bypass_a  = rst_ni && wr_valid && wsel_i[raddr_a_i];
        bypass_b  = rst_ni && wr_valid && wsel_i[raddr_b_i];
        rdata_a_o = !rst_ni ? '0 : (bypass_a ? wdata_i : regs_q[raddr_a_i]);
        rdata_b_o = !rst_ni ? '0 : (bypass_b ? wdata_i : regs_q[raddr_b_i]);
    end

    assign sel_err_o  = sel_err_q;
    assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_regfile8x16.sv
// Directed testbench for regfile8x16: one task per feature, inline comparisons,
// expected values from hand-computed constants and a small register-image model.
module tb_regfile8x16;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [7:0]  wsel;
    logic [15:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [15:0] rdata_a;
    logic [15:0] rdata_b;
    logic        err_clr;
    logic        sel_err;
    logic [7:0]  wr_count;

    int          checks;
    int          errors;
    logic [15:0] exp_regs [8];
    int          exp_cnt;

    regfile8x16 #(.WIDTH(16)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .we_i       (we),
        .wsel_i     (wsel),
        .wdata_i    (wdata),
        .raddr_a_i  (raddr_a),
        .raddr_b_i  (raddr_b),
        .rdata_a_o  (rdata_a),
        .rdata_b_o  (rdata_b),
        .err_clr_i  (err_clr),
        .sel_err_o  (sel_err),
        .wr_count_o (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: one write cycle, driven on the falling edge, idle again after the edge.
    task automatic do_write(input logic [7:0] sel, input logic [15:0] data);
        @(negedge clk);
        we    = 1'b1;
        wsel  = sel;
        wdata = data;
        @(posedge clk);
        #1;
        we   = 1'b0;
        wsel = 8'h00;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            raddr_a = i[2:0];
            raddr_b = 3'(7 - i);
            #1;
            checks++;
            if (rdata_a !== 16'h0000 || rdata_b !== 16'h0000) begin
                errors++;
                $display("FAIL reset_rd[%0d] got a=%h b=%h want 0000", i, rdata_a, rdata_b);
            end
        end
        checks++;
        if (sel_err !== 1'b0 || wr_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_status got err=%b cnt=%0d want 0 0", sel_err, wr_count);
        end
    endtask

    task automatic test_write_sweep();
        for (int i = 0; i < 8; i++) begin
            do_write(8'(1 << i), 16'(16'h1111 * i + 1));
            exp_regs[i] = 16'(16'h1111 * i + 1);
            exp_cnt++;
        end
        for (int i = 0; i < 8; i++) begin
            raddr_a = i[2:0];
            raddr_b = 3'(7 - i);
            #1;
            checks++;
            if (rdata_a !== exp_regs[i] || rdata_b !== exp_regs[7 - i]) begin
                errors++;
                $display("FAIL sweep_rd[%0d] got a=%h b=%h want a=%h b=%h", i, rdata_a, rdata_b,
                         exp_regs[i], exp_regs[7 - i]);
            end
        end
        checks++;
        if (wr_count !== 8'd8) begin
            errors++;
            $display("FAIL sweep_count got %0d want 8", wr_count);
        end
    endtask

    task automatic test_bypass();
        do_write(8'h08, 16'hAAAA);
        exp_cnt++;
        @(negedge clk);
        raddr_a = 3'd3;
        raddr_b = 3'd3;
        #1;
        checks++;
        if (rdata_a !== 16'hAAAA || rdata_b !== 16'hAAAA) begin
            errors++;
            $display("FAIL bypass_pre got a=%h b=%h want aaaa", rdata_a, rdata_b);
        end
        we    = 1'b1;
        wsel  = 8'h08;
        wdata = 16'h5555;
        #1;
        checks++;
        if (rdata_a !== 16'h5555 || rdata_b !== 16'h5555) begin
            errors++;
            $display("FAIL bypass_before_edge got a=%h b=%h want 5555", rdata_a, rdata_b);
        end
        raddr_b = 3'd4;
        #1;
        checks++;
        if (rdata_b !== exp_regs[4]) begin
            errors++;
            $display("FAIL bypass_other_reg got %h want %h", rdata_b, exp_regs[4]);
        end
        raddr_b = 3'd3;
        @(posedge clk);
        #1;
        we   = 1'b0;
        wsel = 8'h00;
        exp_regs[3] = 16'h5555;
        exp_cnt++;
        #1;
        checks++;
        if (rdata_a !== 16'h5555 || rdata_b !== 16'h5555 || wr_count !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL bypass_after_edge got a=%h b=%h cnt=%0d want 5555 cnt=%0d",
                     rdata_a, rdata_b, wr_count, exp_cnt);
        end
    endtask

    task automatic test_invalid_sel();
        // Invalid select must not bypass: ports show stored values before the edge.
        @(negedge clk);
        raddr_a = 3'd2;
        raddr_b = 3'd5;
        we      = 1'b1;
        wsel    = 8'h24;
        wdata   = 16'hFFFF;
        #1;
        checks++;
        if (rdata_a !== exp_regs[2] || rdata_b !== exp_regs[5]) begin
            errors++;
            $display("FAIL invalid_no_bypass got a=%h b=%h want a=%h b=%h", rdata_a, rdata_b,
                     exp_regs[2], exp_regs[5]);
        end
        @(posedge clk);
        #1;
        we   = 1'b0;
        wsel = 8'h00;
        do_write(8'h00, 16'hFFFF);
        for (int i = 0; i < 8; i++) begin
            raddr_a = i[2:0];
            #1;
            checks++;
            if (rdata_a !== exp_regs[i]) begin
                errors++;
                $display("FAIL invalid_reg[%0d] got %h want %h", i, rdata_a, exp_regs[i]);
            end
        end
        checks++;
        if (sel_err !== 1'b1 || wr_count !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL invalid_status got err=%b cnt=%0d want 1 %0d", sel_err, wr_count,
                     exp_cnt);
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        checks++;
        if (sel_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clr got %b want 0", sel_err);
        end
        @(negedge clk);
        err_clr = 1'b1;
        we      = 1'b1;
        wsel    = 8'h81;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        we      = 1'b0;
        wsel    = 8'h00;
        checks++;
        if (sel_err !== 1'b1 || wr_count !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL set_wins got err=%b cnt=%0d want 1 %0d", sel_err, wr_count, exp_cnt);
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic test_we_low();
        raddr_a = 3'd1;
        raddr_b = 3'd6;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            we    = 1'b0;
            wsel  = 8'($urandom);
            wdata = 16'($urandom);
            #1;
            checks++;
            if (rdata_a !== exp_regs[1] || rdata_b !== exp_regs[6]) begin
                errors++;
                $display("FAIL we_low_rd[%0d] got a=%h b=%h want a=%h b=%h", c, rdata_a,
                         rdata_b, exp_regs[1], exp_regs[6]);
            end
        end
        @(posedge clk);
        #1;
        wsel = 8'h00;
        for (int i = 0; i < 8; i++) begin
            raddr_a = i[2:0];
            #1;
            checks++;
            if (rdata_a !== exp_regs[i]) begin
                errors++;
                $display("FAIL we_low_reg[%0d] got %h want %h", i, rdata_a, exp_regs[i]);
            end
        end
        checks++;
        if (sel_err !== 1'b0 || wr_count !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL we_low_status got err=%b cnt=%0d want 0 %0d", sel_err, wr_count,
                     exp_cnt);
        end
    endtask

    task automatic test_back_to_back_saturation();
        // Back-to-back writes to consecutive registers, 300 in total.
        @(negedge clk);
        we = 1'b1;
        for (int n = 0; n < 300; n++) begin
            wsel  = 8'(1 << (n % 8));
            wdata = 16'(16'h0100 + n);
            exp_regs[n % 8] = 16'(16'h0100 + n);
            if (exp_cnt < 255) exp_cnt++;
            @(negedge clk);
        end
        we   = 1'b0;
        wsel = 8'h00;
        checks++;
        if (wr_count !== 8'd255 || exp_cnt != 255) begin
            errors++;
            $display("FAIL saturation got %0d want 255", wr_count);
        end
        for (int i = 0; i < 8; i++) begin
            raddr_a = i[2:0];
            #1;
            checks++;
            if (rdata_a !== exp_regs[i]) begin
                errors++;
                $display("FAIL b2b_reg[%0d] got %h want %h", i, rdata_a, exp_regs[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_write(8'h03, 16'h0BAD);
        @(negedge clk);
        we      = 1'b1;
        wsel    = 8'h01;
        wdata   = 16'hBEEF;
        raddr_a = 3'd0;
        raddr_b = 3'd0;
        #1;
        checks++;
        if (sel_err !== 1'b1 || rdata_a !== 16'hBEEF) begin
            errors++;
            $display("FAIL pre_reset got err=%b a=%h want 1 beef", sel_err, rdata_a);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdata_a !== 16'h0000 || rdata_b !== 16'h0000 || sel_err !== 1'b0 ||
            wr_count !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got a=%h b=%h err=%b cnt=%0d want all 0", rdata_a,
                     rdata_b, sel_err, wr_count);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        we    = 1'b0;
        wsel  = 8'h00;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_regs[i] = 16'h0000;
            raddr_a = i[2:0];
            #1;
            checks++;
            if (rdata_a !== 16'h0000) begin
                errors++;
                $display("FAIL post_reset_reg[%0d] got %h want 0000", i, rdata_a);
            end
        end
        exp_cnt = 0;
        do_write(8'h01, 16'h1234);
        exp_regs[0] = 16'h1234;
        exp_cnt++;
        raddr_a = 3'd0;
        raddr_b = 3'd1;
        #1;
        checks++;
        if (rdata_a !== 16'h1234 || rdata_b !== 16'h0000 || wr_count !== 8'd1) begin
            errors++;
            $display("FAIL first_write got a=%h b=%h cnt=%0d want 1234 0000 1", rdata_a,
                     rdata_b, wr_count);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) exp_regs[i] = 16'h0000;
        rst_n   = 1'b0;
        we      = 1'b0;
        wsel    = 8'h00;
        wdata   = 16'h0000;
        raddr_a = 3'd0;
        raddr_b = 3'd0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_write_sweep();
        test_bypass();
        test_invalid_sel();
        test_we_low();
        test_back_to_back_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
